// File: rtl/lpcm_monitor.sv
// lpcm_monitor: pin-level receiver for the LPCM interface.
// Rebuilds {sample, latency} items from the en/data pins. An item is held
// until the next en (or a flush) closes its idle gap, and then it is queued
// in a small FIFO that drains over a valid/ready response port.
// Optional build macro: LPCM_MONITOR_STATS_EN adds the stat_count and
// stat_max_lat outputs.
module lpcm_monitor #(
    parameter int SAMPLE_W   = 24,
    parameter int LAT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] data,
    input  logic                flush,
    input  logic                rsp_ready,
    output logic                rsp_en,
    output logic [SAMPLE_W-1:0] rsp_sample,
    output logic [LAT_W-1:0]    rsp_latency,
    output logic                overflow
`ifdef LPCM_MONITOR_STATS_EN
    ,
    output logic [31:0]         stat_count,
    output logic [LAT_W-1:0]    stat_max_lat
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [SAMPLE_W-1:0] sample;
        logic [LAT_W-1:0]    latency;
    } item_t;

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic [LAT_W-1:0]    gap_q, gap_d;
    logic                push;
    item_t               push_item;

    item_t               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                full, pop, accept;
    item_t               head;

    // Item builder state: held sample, its running idle gap, and FSM state.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= EMPTY;
            hold_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic: en closes the held item (and has priority over flush);
    // flush closes it using the gap counted so far.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        push      = 1'b0;
        push_item = '{sample: hold_q, latency: gap_q};
        case (state_q)
            EMPTY: begin
                if (en) begin
                    hold_d  = data;
                    gap_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (en) begin
                    push   = 1'b1;
                    hold_d = data;
                    gap_d  = '0;
                end else begin
                    // Saturate rather than wrap so long gaps read as "max".
                    if (gap_q != '1) gap_d = gap_q + LAT_W'(1);
                    if (flush) begin
                        push    = 1'b1;
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // A push into a full FIFO still lands when the head leaves in the same
    // cycle: the freed slot is the one wr_ptr points at.
    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign pop    = rsp_en && rsp_ready;
    assign accept = push && (!full || pop);

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    // Item storage; contents are only observed through the count-gated head.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= push_item;
    end

    assign head        = mem[rd_ptr];
    assign rsp_en      = (count != '0);
    assign rsp_sample  = rsp_en ? head.sample  : '0;
    assign rsp_latency = rsp_en ? head.latency : '0;

`ifdef LPCM_MONITOR_STATS_EN
    // Accepted-item count and worst latency seen; dropped items are excluded.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            stat_count   <= '0;
            stat_max_lat <= '0;
        end else if (accept) begin
            stat_count <= stat_count + 32'd1;
            if (push_item.latency > stat_max_lat) stat_max_lat <= push_item.latency;
        end
    end
`endif

endmodule

// File: tb/tb_lpcm_monitor.sv
// tb_lpcm_monitor: directed stimulus with a scoreboard queue. Stimulus pushes
// the expected item when it drives the edge that completes it; a negedge
// monitor pops and compares on every handshake.
module tb_lpcm_monitor;

    localparam int SAMPLE_W   = 24;
    localparam int LAT_W      = 4;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [SAMPLE_W-1:0] s;
        logic [LAT_W-1:0]    l;
    } item_t;

    logic                clk;
    logic                resetb;
    logic                en;
    logic [SAMPLE_W-1:0] data;
    logic                flush;
    logic                rsp_ready;
    logic                rsp_en;
    logic [SAMPLE_W-1:0] rsp_sample;
    logic [LAT_W-1:0]    rsp_latency;
    logic                overflow;
`ifdef LPCM_MONITOR_STATS_EN
    logic [31:0]         stat_count;
    logic [LAT_W-1:0]    stat_max_lat;
`endif

    int    checks   = 0;
    int    failures = 0;
    item_t exp_q[$];
    item_t mon_item;

    lpcm_monitor #(
        .SAMPLE_W  (SAMPLE_W),
        .LAT_W     (LAT_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .en         (en),
        .data       (data),
        .flush      (flush),
        .rsp_ready  (rsp_ready),
        .rsp_en     (rsp_en),
        .rsp_sample (rsp_sample),
        .rsp_latency(rsp_latency),
        .overflow   (overflow)
`ifdef LPCM_MONITOR_STATS_EN
        ,
        .stat_count  (stat_count),
        .stat_max_lat(stat_max_lat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [SAMPLE_W-1:0] s, input logic [LAT_W-1:0] l);
        exp_q.push_back('{s: s, l: l});
    endtask

    task automatic wait_empty(input int max_cycles);
        int n = 0;
        while (rsp_en && n < max_cycles) begin
            step();
            n++;
        end
        chk("drain_timeout", {31'd0, rsp_en}, 32'd0);
    endtask

    // Monitor: compare the head against the scoreboard on each accepted pop,
    // and require zeroed outputs whenever the FIFO is empty.
    always @(negedge clk) begin
        if (resetb) begin
            if (rsp_en) begin
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_item: got 0x%0h/%0d expected none at %0t",
                                 rsp_sample, rsp_latency, $time);
                    end else begin
                        mon_item = exp_q.pop_front();
                        chk("item_sample", 32'(rsp_sample), 32'(mon_item.s));
                        chk("item_latency", 32'(rsp_latency), 32'(mon_item.l));
                    end
                end
            end else begin
                chk("empty_sample", 32'(rsp_sample), 32'd0);
                chk("empty_latency", 32'(rsp_latency), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        resetb = 1'b0; en = 1'b0; data = '0; flush = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_en", {31'd0, rsp_en}, 32'd0);
        chk("reset_sample", 32'(rsp_sample), 32'd0);
        chk("reset_latency", 32'(rsp_latency), 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        resetb = 1'b1;
        step();

        // Latency recovery: {0x11,3} then {0x22,1}.
        rsp_ready = 1'b1;
        en = 1'b1; data = 24'h000011; step();
        en = 1'b0;
        repeat (3) begin data = SAMPLE_W'($urandom); step(); end
        chk("pre_item_rsp_en", {31'd0, rsp_en}, 32'd0);
        en = 1'b1; data = 24'h000022; push_exp(24'h11, 4'd3); step();
        chk("rsp_en_rise", {31'd0, rsp_en}, 32'd1);
        chk("first_head", 32'(rsp_sample), 32'h11);
        en = 1'b0; data = SAMPLE_W'($urandom); step();
        flush = 1'b1; push_exp(24'h22, 4'd1); step();
        flush = 1'b0;
        repeat (3) step();
        // Flush while EMPTY must not produce anything.
        flush = 1'b1; step();
        flush = 1'b0;
        repeat (3) step();

        // Back-to-back samples give latency 0.
        en = 1'b1;
        data = 24'd1; step();
        data = 24'd2; push_exp(24'd1, 4'd0); step();
        data = 24'd3; push_exp(24'd2, 4'd0); step();
        data = 24'd4; push_exp(24'd3, 4'd0); step();
        en = 1'b0; flush = 1'b1; push_exp(24'd4, 4'd0); step();
        flush = 1'b0;
        wait_empty(10);

        // Saturation, then en+flush collision: en wins, 0xB stays held.
        en = 1'b1; data = 24'h00000A; step();
        en = 1'b0;
        repeat (20) begin data = SAMPLE_W'($urandom); step(); end
        en = 1'b1; flush = 1'b1; data = 24'h00000B; push_exp(24'hA, 4'd15); step();
        en = 1'b0; flush = 1'b0;
        step(); step();
        flush = 1'b1; push_exp(24'hB, 4'd2); step();
        flush = 1'b0;
        wait_empty(10);

        // Full FIFO with a push and a pop in the same cycle.
        rsp_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data = 24'h200 + 24'(i);
            if (i > 0) push_exp(24'h200 + 24'(i - 1), 4'd0);
            step();
        end
        chk("full_rsp_en", {31'd0, rsp_en}, 32'd1);
        data = 24'h205; push_exp(24'h204, 4'd0); rsp_ready = 1'b1; step();
        rsp_ready = 1'b0; en = 1'b0;
        chk("full_pop_no_ovf", {31'd0, overflow}, 32'd0);
        chk("full_pop_head", 32'(rsp_sample), 32'h201);
        step();
        chk("full_pop_no_ovf2", {31'd0, overflow}, 32'd0);
        rsp_ready = 1'b1;
        repeat (20) step();
        flush = 1'b1; push_exp(24'h205, 4'd15); step();
        flush = 1'b0;
        wait_empty(10);
        chk("q_after_fullpop", exp_q.size(), 32'd0);

        // Backpressure and overflow: 5th item dropped, flag sticky.
        rsp_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data = 24'h300 + 24'(i);
            if (i > 0 && i < 5) push_exp(24'h300 + 24'(i - 1), 4'd0);
            if (i == 5) chk("ovf_before_drop", {31'd0, overflow}, 32'd0);
            step();
        end
        chk("ovf_after_drop", {31'd0, overflow}, 32'd1);
        chk("bp_head", 32'(rsp_sample), 32'h300);
        en = 1'b0; data = SAMPLE_W'($urandom);
        step(); step();
        chk("bp_head_stable", 32'(rsp_sample), 32'h300);
        chk("bp_lat_stable", 32'(rsp_latency), 32'd0);
        rsp_ready = 1'b1;
        repeat (20) step();
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("bp_drained", {31'd0, rsp_en}, 32'd0);

`ifdef LPCM_MONITOR_STATS_EN
        chk("stat_count_pre", stat_count, 32'd18);
        chk("stat_max_lat_pre", 32'(stat_max_lat), 32'd15);
`endif

        // Reset mid-stream with HOLD active and two items queued.
        rsp_ready = 1'b0;
        flush = 1'b1; step();
        flush = 1'b0;
        en = 1'b1; data = 24'h400; step();
        data = 24'h401; step();
        en = 1'b0;
        chk("pre_reset_rsp_en", {31'd0, rsp_en}, 32'd1);
        #2 resetb = 1'b0;
        #1;
        chk("mid_reset_rsp_en", {31'd0, rsp_en}, 32'd0);
        chk("mid_reset_sample", 32'(rsp_sample), 32'd0);
        chk("mid_reset_overflow", {31'd0, overflow}, 32'd0);
        exp_q.delete();
        step();
        #2 resetb = 1'b1;
        step();
        rsp_ready = 1'b1;
        en = 1'b1; data = 24'h500; step();
        en = 1'b0; data = SAMPLE_W'($urandom);
        step(); step();
        chk("no_item_after_reset", {31'd0, rsp_en}, 32'd0);
`ifdef LPCM_MONITOR_STATS_EN
        chk("stat_count_reset", stat_count, 32'd0);
`endif
        flush = 1'b1; push_exp(24'h500, 4'd2); step();
        flush = 1'b0;
        wait_empty(10);
        step();
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lpcm_monitor.md
Name: lpcm_monitor

Overview:
- Receive-side counterpart of the LPCM stimulus driver. Samples the LPCM `en`/`data` pins and rebuilds transaction items.
- Each item is a sample plus the number of idle cycles that followed it, i.e. the latency the driver inserted after that sample.
- Items are buffered in a small FIFO and presented on a valid/ready response port to the scoreboard or checker.
- A pin-level receiver cannot know an item's latency until the next `en` arrives, so each item is held until the next sample or an explicit `flush`.

Parameters:
- SAMPLE_W, 24, width of the `data` bus and of `rsp_sample`.
- LAT_W, 8, width of the measured latency. The count saturates at 2^LAT_W-1.
- FIFO_DEPTH, 4, number of item slots. Must be a power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetb  input  1  asynchronous active-low reset.
- en  input  1  LPCM sample strobe.
- data  input  SAMPLE_W  LPCM sample; only meaningful when `en` is 1.
- flush  input  1  1-cycle pulse: emit the held sample, using the gap counted so far as its latency.
- rsp_ready  input  1  consumer accepts the FIFO head.
- rsp_en  output  1  FIFO non-empty; the head item is valid.
- rsp_sample  output  SAMPLE_W  head item sample.
- rsp_latency  output  LAT_W  head item latency (idle cycles after that sample).
- overflow  output  1  sticky flag: an item was dropped because the FIFO was full.

Behaviour:
- Reset (resetb=0, asynchronous):
  - State goes to EMPTY; hold register, gap counter and FIFO pointers/count are cleared.
  - Outputs: rsp_en=0, rsp_sample=0, rsp_latency=0, overflow=0.
  - Reset asserted mid-operation discards the held item and all FIFO contents.
- States:
  - EMPTY: no sample held.
  - HOLD: one sample held; gap counter running.
- EMPTY, en=1: hold <= data, gap <= 0, go to HOLD.
- EMPTY, en=0: no action. flush has no effect.
- HOLD, en=0:
  - gap <= gap+1, saturating at 2^LAT_W-1.
  - If flush=1: push {hold, gap} and go to EMPTY. The pushed gap is the pre-increment value.
- HOLD, en=1:
  - push {hold, gap}, hold <= data, gap <= 0, stay in HOLD.
  - flush in the same cycle is ignored; en takes precedence.
- Back-to-back `en` produces latency 0.
- `data` is never sampled when en=0. X or random values on `data` must not affect state.
- FIFO:
  - Pop when rsp_en && rsp_ready.
  - A pushed item is visible on the outputs the cycle after the push edge: 1-cycle latency from the `en` edge that completes the item.
  - Push while full with a simultaneous pop: accepted, count unchanged.
  - Push while full with no pop: item dropped, overflow <= 1. overflow is cleared only by reset.
  - Pop while empty: impossible, since rsp_en=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Output values:
  - rsp_sample and rsp_latency show the FIFO head when rsp_en=1.
  - They are 0 when the FIFO is empty.
  - They are stable while rsp_en=1 and rsp_ready=0.
- Ordering: items leave in arrival order.

Optional Feature:
- Macro: LPCM_MONITOR_STATS_EN.
- Defined: adds outputs `stat_count` [31:0] and `stat_max_lat` [LAT_W-1:0], both reset to 0.
  - stat_count increments on every accepted FIFO push (dropped items are not counted) and wraps at 2^32.
  - stat_max_lat tracks the largest latency pushed.
- Not defined: neither port nor its logic exists. All other behaviour is identical.

Test Plan:
- Latency recovery: en=1 data=0x000011, 3 idle cycles, en=1 data=0x000022, 1 idle cycle, flush -> items {0x11, 3} then {0x22, 1}. rsp_en rises 1 cycle after the second en edge.
- Back-to-back: en=1 for 4 cycles with data 1,2,3,4, then flush the next cycle -> items {1,0},{2,0},{3,0},{4,0}.
- Saturation and collision: LAT_W=4, sample 0xA, 20 idle cycles, then en=1 and flush in the same cycle with data 0xB -> {0xA, 15} emitted. Monitor stays in HOLD with 0xB, and the flush is ignored.
- Backpressure and overflow: FIFO_DEPTH=4, rsp_ready=0, 6 samples back-to-back -> 4 items stored, 5th dropped, overflow=1. Raise rsp_ready -> first 4 samples drain in order. overflow stays 1.
- Full with simultaneous pop: FIFO full, rsp_ready=1 in the same cycle as a push -> overflow stays 0 and the count stays at 4.
- Reset mid-stream: resetb=0 while HOLD and FIFO count is 2 -> rsp_en=0 immediately. After release, the first en only fills HOLD and no item is emitted. With LPCM_MONITOR_STATS_EN defined, stat_count=0.
